pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the five-stage pipeline latches (fetch, decode, execute, memory). Each cycle it produces the PC enable and the per-latch enable/flush pair from cache hits, load-use hazards, memory-stage redirects and halt. It owns a small FSM for data-memory waits and halt drain. It also keeps a saturating stall counter and a sticky memory-timeout flag for debug.

Parameters:
CNT_W, 16, width of stall_cnt (saturating)
MAX_WAIT, 64, consecutive DWAIT cycles after which mem_timeout sets

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
ihit  in  1  instruction cache hit this cycle
dhit  in  1  data cache hit this cycle
mem_dREN, mem_dWEN  in  1 each  memory-stage data request
mem_branch_taken, mem_jump  in  1 each  redirect resolved in memory stage
mem_halt  in  1  halt instruction in memory stage
wb_halt  in  1  halt at memory-latch output
ex_MemtoReg  in  1  execute-stage instruction is a load
ex_wsel  in  5  execute-stage destination register
dec_rs, dec_rt  in  5 each  decode-stage source registers
pc_en  out  1  PC update enable
fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush  out  1 each  latch controls
halted  out  1  processor halted
state  out  2  RUN=0, DWAIT=1, DRAIN=2, HALTED=3
stall_cnt  out  CNT_W  saturating stall-cycle count
mem_timeout  out  1  sticky: DWAIT exceeded MAX_WAIT

Behaviour:
- Latch contract: flush=1 clears the latch regardless of en. The controller always drives en=1 alongside flush=1.
- Outputs are combinational from the registered state and current inputs. Only state, the wait counter, stall_cnt and mem_timeout are registered.
- RST=1 on a clock edge sets: state=RUN, stall_cnt=0, wait counter=0, mem_timeout=0. While RST=1, all en/flush, pc_en and halted are driven 0.
- Derived terms:
  - dwait = (mem_dREN|mem_dWEN) & !dhit
  - lu = ex_MemtoReg & ex_wsel!=0 & (ex_wsel==dec_rs | ex_wsel==dec_rt)
  - redir = mem_branch_taken | mem_jump
- RUN and DWAIT apply the same rules, highest priority first:
  1. dwait: all en, flush and pc_en are 0 (full freeze); next=DWAIT.
  2. mem_halt: pc_en=0; fl/dl/el flushed; ml_en=1; next=DRAIN.
  3. redir: pc_en=1; fl/dl/el flushed; ml_en=1; next=RUN. Applies regardless of ihit.
  4. !ihit: pc_en=0; fl_flush=1 (bubble to decode); dl/el/ml en=1; next=RUN.
  5. lu: pc_en=0; fl_en=0 (hold); dl_flush=1 (bubble to execute); el/ml en=1; next=RUN.
  6. Otherwise: all en=1, pc_en=1, no flush; next=RUN.
- Wait counter:
  - Increments each cycle state==DWAIT and dwait=1.
  - Clears on any transition to RUN.
  - When it reaches MAX_WAIT, mem_timeout sets and stays set until RST. FSM behaviour is unchanged.
- DRAIN: pc_en=0; fl/dl/el flushed; ml_en=0 (holds halt at latch output); ml_flush=0. If wb_halt=1, next=HALTED; otherwise remain in DRAIN.
- HALTED: all en/flush and pc_en are 0; halted=1. Exit only via RST.
- stall_cnt: +1 in any cycle where rule 1 or rule 5 fires. Saturates at all-ones. Holds in DRAIN and HALTED.
- Simultaneous events: dwait beats halt/redir/lu; halt beats redir; redir beats ihit/lu (a load-use pair behind a taken branch is flushed, not stalled).
- ex_wsel=0 never raises lu.
- dhit with no request is ignored.
- RST asserted mid-DWAIT or mid-DRAIN returns to RUN on that edge.

Test Plan:
- Reset: RST=1 for 2 cycles, then 0 with ihit=1 and no hazards -> state=0, stall_cnt=0, all en=1, pc_en=1, no flushes.
- Load-use: ex_MemtoReg=1, ex_wsel=5, dec_rt=5, ihit=1 for one cycle -> pc_en=0, fl_en=0, dl_flush=1, el_en=1, stall_cnt=1. Same stimulus with ex_wsel=0 -> no stall.
- D-miss: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> all en=0 for 3 cycles, state=1, stall_cnt=3; on the dhit cycle rule 6 applies and state returns to 0.
- Redirect priority: mem_jump=1 with ihit=0 and lu=1 -> pc_en=1; fl/dl/el flush=1; ml_en=1; stall_cnt unchanged.
- Halt drain: mem_halt=1 -> state=2 next; wb_halt=1 -> state=3, halted=1; all en=0 held for 10 cycles with ihit=1.
- Timeout: MAX_WAIT=4, mem_dWEN=1, dhit=0 for 6 cycles -> mem_timeout=1 after the 4th DWAIT cycle; it stays 1 after dhit returns; RST clears it.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline hazard controller signal bundle
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             mem_branch_taken;
  logic             mem_jump;
  logic             mem_halt;
  logic             wb_halt;
  logic             ex_MemtoReg;
  logic [4:0]       ex_wsel;
  logic [4:0]       dec_rs;
  logic [4:0]       dec_rt;
  logic             pc_en;
  logic             fl_en;
  logic             fl_flush;
  logic             dl_en;
  logic             dl_flush;
  logic             el_en;
  logic             el_flush;
  logic             ml_en;
  logic             ml_flush;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_timeout;

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, mem_branch_taken, mem_jump,
           mem_halt, wb_halt, ex_MemtoReg, ex_wsel, dec_rs, dec_rt,
    input  pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush,
           ml_en, ml_flush, halted, state, stall_cnt, mem_timeout
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, mem_branch_taken, mem_jump,
           mem_halt, wb_halt, ex_MemtoReg, ex_wsel, dec_rs, dec_rt,
    output pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush,
           ml_en, ml_flush, halted, state, stall_cnt, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline latch sequencer with d-miss wait and halt drain FSM
module pipeline_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input logic                  CLK,
  input logic                  RST,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, DRAIN = 2'd2, HALTED = 2'd3} state_t;

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  state_t           st_q, st_d;
  logic [WW-1:0]    wait_q;
  logic [CNT_W-1:0] stall_q;
  logic             timeout_q;

  logic dwait, lu, redir, stall_inc;
  logic pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush, halted;

  assign dwait = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;
  assign lu    = bus.ex_MemtoReg & (bus.ex_wsel != 5'd0) &
                 ((bus.ex_wsel == bus.dec_rs) | (bus.ex_wsel == bus.dec_rt));
  assign redir = bus.mem_branch_taken | bus.mem_jump;

  always_comb begin
    st_d      = st_q;
    stall_inc = 1'b0;
    pc_en     = 1'b0;
    fl_en     = 1'b0;
    fl_flush  = 1'b0;
    dl_en     = 1'b0;
    dl_flush  = 1'b0;
    el_en     = 1'b0;
    el_flush  = 1'b0;
    ml_en     = 1'b0;
    ml_flush  = 1'b0;
    halted    = 1'b0;
    if (!RST) begin
      case (st_q)
        RUN, DWAIT: begin
          if (dwait) begin
            st_d      = DWAIT;
            stall_inc = 1'b1;
          end else if (bus.mem_halt) begin
            {fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush} = 6'b111111;
            ml_en = 1'b1;
            st_d  = DRAIN;
          end else if (redir) begin
            // Wrong-path work in the upper latches is discarded, so ihit and lu do not matter.
            pc_en = 1'b1;
            {fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush} = 6'b111111;
            ml_en = 1'b1;
            st_d  = RUN;
          end else if (!bus.ihit) begin
            fl_en    = 1'b1;
            fl_flush = 1'b1;
            dl_en    = 1'b1;
            el_en    = 1'b1;
            ml_en    = 1'b1;
            st_d     = RUN;
          end else if (lu) begin
            dl_en     = 1'b1;
            dl_flush  = 1'b1;
            el_en     = 1'b1;
            ml_en     = 1'b1;
            stall_inc = 1'b1;
            st_d      = RUN;
          end else begin
            {pc_en, fl_en, dl_en, el_en, ml_en} = 5'b11111;
            st_d = RUN;
          end
        end
        DRAIN: begin
          // Memory latch holds so the halt stays visible at its output until it is seen.
          {fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush} = 6'b111111;
          if (bus.wb_halt) st_d = HALTED;
        end
        default: begin
          halted = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q      <= RUN;
      wait_q    <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_d == RUN) begin
        wait_q <= '0;
      end else if (st_q == DWAIT && dwait && wait_q != WAIT_MAX) begin
        wait_q <= wait_q + 1'b1;
      end
      if (st_q == DWAIT && dwait && wait_q >= WAIT_LAST) begin
        timeout_q <= 1'b1;
      end
      if (stall_inc && stall_q != {CNT_W{1'b1}}) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.fl_en       = fl_en;
  assign bus.fl_flush    = fl_flush;
  assign bus.dl_en       = dl_en;
  assign bus.dl_flush    = dl_flush;
  assign bus.el_en       = el_en;
  assign bus.el_flush    = el_flush;
  assign bus.ml_en       = ml_en;
  assign bus.ml_flush    = ml_flush;
  assign bus.halted      = halted;
  assign bus.state       = st_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.mem_timeout = timeout_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed table-driven bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic clk;
  logic rst;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) i1 ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  i2 ();

  pipeline_hazard_ctrl #(.CNT_W(16), .MAX_WAIT(4)) dut (.CLK(clk), .RST(rst), .bus(i1.slave));
  pipeline_hazard_ctrl #(.CNT_W(2),  .MAX_WAIT(4)) dut_sat (.CLK(clk), .RST(rst), .bus(i2.slave));

  assign i2.ihit             = i1.ihit;
  assign i2.dhit             = i1.dhit;
  assign i2.mem_dREN         = i1.mem_dREN;
  assign i2.mem_dWEN         = i1.mem_dWEN;
  assign i2.mem_branch_taken = i1.mem_branch_taken;
  assign i2.mem_jump         = i1.mem_jump;
  assign i2.mem_halt         = i1.mem_halt;
  assign i2.wb_halt          = i1.wb_halt;
  assign i2.ex_MemtoReg      = i1.ex_MemtoReg;
  assign i2.ex_wsel          = i1.ex_wsel;
  assign i2.dec_rs           = i1.dec_rs;
  assign i2.dec_rt           = i1.dec_rt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush, halted}
  localparam logic [9:0] C_N   = 10'b1101010100;
  localparam logic [9:0] C_FRZ = 10'b0000000000;
  localparam logic [9:0] C_LU  = 10'b0001110100;
  localparam logic [9:0] C_IM  = 10'b0111010100;
  localparam logic [9:0] C_RD  = 10'b1111111100;
  localparam logic [9:0] C_HL  = 10'b0111111100;
  localparam logic [9:0] C_DR  = 10'b0111111000;
  localparam logic [9:0] C_HT  = 10'b0000000001;

  // input bits: {ihit, dhit, dREN, dWEN, branch_taken, jump, mem_halt, wb_halt, MemtoReg}
  localparam logic [8:0] B_I = 9'b100000000;

  typedef struct {
    logic [8:0] b;
    logic [4:0] wsel;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [9:0] ctl;
    logic [1:0] st;
    int         cnt;
  } vec_t;

  vec_t v[22];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic [8:0] b, logic [4:0] w, logic [4:0] rs, logic [4:0] rt,
                              logic [9:0] c, logic [1:0] s, int n);
    vec_t r;
    r.b = b; r.wsel = w; r.rs = rs; r.rt = rt; r.ctl = c; r.st = s; r.cnt = n;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [8:0] b, input logic [4:0] w, input logic [4:0] rs,
                        input logic [4:0] rt);
    {i1.ihit, i1.dhit, i1.mem_dREN, i1.mem_dWEN, i1.mem_branch_taken, i1.mem_jump,
     i1.mem_halt, i1.wb_halt, i1.ex_MemtoReg} = b;
    i1.ex_wsel = w;
    i1.dec_rs  = rs;
    i1.dec_rt  = rt;
  endtask

  function automatic logic [9:0] ctl_now();
    return {i1.pc_en, i1.fl_en, i1.fl_flush, i1.dl_en, i1.dl_flush,
            i1.el_en, i1.el_flush, i1.ml_en, i1.ml_flush, i1.halted};
  endfunction

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    v[0]  = mk(B_I,          5'd0, 5'd0, 5'd0, C_N,   2'd0, 0);
    v[1]  = mk(9'b100000001, 5'd5, 5'd0, 5'd5, C_LU,  2'd0, 0);
    v[2]  = mk(B_I,          5'd0, 5'd0, 5'd0, C_N,   2'd0, 1);
    v[3]  = mk(9'b100000001, 5'd0, 5'd0, 5'd0, C_N,   2'd0, 1);
    v[4]  = mk(9'b100000001, 5'd7, 5'd7, 5'd3, C_LU,  2'd0, 1);
    v[5]  = mk(B_I,          5'd0, 5'd0, 5'd0, C_N,   2'd0, 2);
    v[6]  = mk(9'b000000000, 5'd0, 5'd0, 5'd0, C_IM,  2'd0, 2);
    v[7]  = mk(9'b110000000, 5'd0, 5'd0, 5'd0, C_N,   2'd0, 2);
    v[8]  = mk(9'b101000000, 5'd0, 5'd0, 5'd0, C_FRZ, 2'd0, 2);
    v[9]  = mk(9'b101000000, 5'd0, 5'd0, 5'd0, C_FRZ, 2'd1, 3);
    v[10] = mk(9'b101000000, 5'd0, 5'd0, 5'd0, C_FRZ, 2'd1, 4);
    v[11] = mk(9'b111000000, 5'd0, 5'd0, 5'd0, C_N,   2'd1, 5);
    v[12] = mk(B_I,          5'd0, 5'd0, 5'd0, C_N,   2'd0, 5);
    v[13] = mk(9'b000001001, 5'd5, 5'd0, 5'd5, C_RD,  2'd0, 5);
    v[14] = mk(9'b100010000, 5'd0, 5'd0, 5'd0, C_RD,  2'd0, 5);
    v[15] = mk(B_I,          5'd0, 5'd0, 5'd0, C_N,   2'd0, 5);
    v[16] = mk(9'b100101100, 5'd0, 5'd0, 5'd0, C_FRZ, 2'd0, 5);
    v[17] = mk(9'b100001100, 5'd0, 5'd0, 5'd0, C_HL,  2'd1, 6);
    v[18] = mk(B_I,          5'd0, 5'd0, 5'd0, C_DR,  2'd2, 6);
    v[19] = mk(9'b101000000, 5'd0, 5'd0, 5'd0, C_DR,  2'd2, 6);
    v[20] = mk(9'b100000010, 5'd0, 5'd0, 5'd0, C_DR,  2'd2, 6);
    v[21] = mk(B_I,          5'd0, 5'd0, 5'd0, C_HT,  2'd3, 6);

    rst = 1'b1;
    set_in(B_I, 5'd0, 5'd0, 5'd0);
    next_cycle();
    #1 chk("reset_ctl", 32'(ctl_now()), 32'd0);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      set_in(v[i].b, v[i].wsel, v[i].rs, v[i].rt);
      #1;
      chk($sformatf("row%0d_ctl", i), 32'(ctl_now()), 32'(v[i].ctl));
      chk($sformatf("row%0d_state", i), 32'(i1.state), 32'(v[i].st));
      chk($sformatf("row%0d_stall_cnt", i), 32'(i1.stall_cnt), v[i].cnt);
      chk($sformatf("row%0d_sat_cnt", i), 32'(i2.stall_cnt), (v[i].cnt > 3) ? 32'd3 : v[i].cnt);
      chk($sformatf("row%0d_timeout", i), 32'(i1.mem_timeout), 32'd0);
      next_cycle();
    end

    // HALTED holds for ten cycles regardless of ihit
    for (int k = 0; k < 10; k++) begin
      set_in(B_I, 5'd0, 5'd0, 5'd0);
      #1;
      chk($sformatf("halted_hold%0d_ctl", k), 32'(ctl_now()), 32'(C_HT));
      chk($sformatf("halted_hold%0d_state", k), 32'(i1.state), 32'd3);
      next_cycle();
    end

    rst = 1'b1;
    #1 chk("rst_from_halted_ctl", 32'(ctl_now()), 32'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    chk("post_rst_state", 32'(i1.state), 32'd0);
    chk("post_rst_cnt", 32'(i1.stall_cnt), 32'd0);
    chk("post_rst_ctl", 32'(ctl_now()), 32'(C_N));
    next_cycle();

    // reset while draining
    set_in(9'b100000100, 5'd0, 5'd0, 5'd0);
    next_cycle();
    set_in(B_I, 5'd0, 5'd0, 5'd0);
    #1 chk("drain_entered", 32'(i1.state), 32'd2);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1 chk("rst_mid_drain_state", 32'(i1.state), 32'd0);
    next_cycle();

    // reset while waiting on a data miss
    set_in(9'b101000000, 5'd0, 5'd0, 5'd0);
    next_cycle();
    next_cycle();
    #1 chk("dwait_entered", 32'(i1.state), 32'd1);
    chk("dwait_cnt", 32'(i1.stall_cnt), 32'd2);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_in(B_I, 5'd0, 5'd0, 5'd0);
    #1;
    chk("rst_mid_dwait_state", 32'(i1.state), 32'd0);
    chk("rst_mid_dwait_cnt", 32'(i1.stall_cnt), 32'd0);
    next_cycle();

    // timeout: one RUN cycle then DWAIT; sets on the 4th DWAIT cycle
    set_in(9'b100100000, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("timeout_c%0d", k), 32'(i1.mem_timeout), (k >= 5) ? 32'd1 : 32'd0);
      next_cycle();
    end
    set_in(9'b110100000, 5'd0, 5'd0, 5'd0);
    #1 chk("timeout_sticky_hit", 32'(i1.mem_timeout), 32'd1);
    next_cycle();
    set_in(B_I, 5'd0, 5'd0, 5'd0);
    #1;
    chk("timeout_sticky_run", 32'(i1.mem_timeout), 32'd1);
    chk("timeout_back_to_run", 32'(i1.state), 32'd0);
    chk("timeout_stall_cnt", 32'(i1.stall_cnt), 32'd6);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1 chk("timeout_cleared", 32'(i1.mem_timeout), 32'd0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
